reg_write_arbiter: RTL
======================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter: MAX_ADDR, 4, highest valid register address; writes above it are rejected.
REQ-002 Parameter: SYNC_UPDATE, 1, 1 = writes land in shadow and reach outputs only at PWM period end; 0 = writes reach outputs directly.
REQ-003 clk  input  1  single block clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 a_valid  input  1  requester A (SPI commit path) write request.
REQ-006 a_addr  input  7  requester A register address.
REQ-007 a_data  input  8  requester A write data.
REQ-008 a_ready  output  1  requester A write accepted this cycle.
REQ-009 b_valid, b_addr, b_data, b_ready  as A, 1/7/8/1 bits  requester B (on-chip sequencer) port.
REQ-010 period_end  input  1  one-cycle pulse marking PWM period boundary.
REQ-011 en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle  output  8 each  active register values, addresses 0..4.
REQ-012 update_pending  output  1  shadow holds data not yet copied to outputs.
REQ-013 addr_err  output  1  one-cycle pulse: an accepted write had address > MAX_ADDR.
REQ-014 last_grant  output  1  0 = A, 1 = B; requester granted most recently.

Function
REQ-015 At most one write SHALL be accepted per cycle; x_ready = x_valid AND granted, combinational from current valids and the priority state.
REQ-016 Arbitration SHALL be two-state round-robin: state PRIO_A or PRIO_B; a lone valid requester is always granted; with both valid, the prioritised requester wins.
REQ-017 After any accepted write the priority state SHALL move to favour the non-granted requester; with no acceptance it SHALL hold.
REQ-018 A requester SHALL hold valid, addr and data stable until ready; a dropped valid before ready SHALL be permitted and leaves no side effect.
REQ-019 An accepted write with address <= MAX_ADDR SHALL update the shadow register at that address on the same clock edge (SYNC_UPDATE=1) or the output register directly (SYNC_UPDATE=0).
REQ-020 An accepted write with address > MAX_ADDR SHALL change no register and SHALL assert addr_err for exactly the next cycle.
REQ-021 SYNC_UPDATE=1: a valid write SHALL set update_pending; on period_end with update_pending=1 all five outputs SHALL load shadow values and update_pending SHALL clear, visible one cycle after the pulse.
REQ-022 period_end coinciding with an accepted valid write: outputs SHALL load pre-write shadow contents and update_pending SHALL remain 1.
REQ-023 period_end with update_pending=0 SHALL leave outputs unchanged.
REQ-024 SYNC_UPDATE=0: update_pending SHALL be held 0 and period_end ignored.
REQ-025 Latency from acceptance to output SHALL be one cycle (SYNC_UPDATE=0) or first period_end edge after acceptance plus one cycle (SYNC_UPDATE=1).

Reset
REQ-026 On rst_n=0 at a clock edge: all outputs and shadows 0x00, priority PRIO_A, update_pending 0, addr_err 0, last_grant 0.
REQ-027 While rst_n=0, a_ready and b_ready SHALL be 0; reset mid-operation SHALL discard pending shadow contents.

Structure
REQ-028 Shared package SHALL hold register address constants (0..4), NUM_REGS=5, address/data widths and requester ID encoding.
REQ-029 Arbitration SHALL be one sub-module, rr_arbiter2, holding the priority state; register bank and shadow logic stay in the top.

Verification
REQ-030 A writes addr 4 data 0x80, SYNC_UPDATE=1 -> pwm_duty_cycle stays 0x00, update_pending=1; period_end pulse -> 0x80 one cycle later, pending clears.
REQ-031 A and B valid together for 4 consecutive writes each, from reset -> grants A,B,A,B,... ; no cycle with both ready.
REQ-032 B writes addr 7 data 0xFF -> b_ready=1, addr_err pulse one cycle, all registers unchanged.
REQ-033 Write addr 0 data 0x5A coinciding with period_end, prior shadow 0x00 pending -> output 0x00 after pulse, pending=1; next period_end -> 0x5A.
REQ-034 SYNC_UPDATE=0, A writes addr 2 data 0x0F -> en_reg_pwm_7_0=0x0F next cycle, update_pending 0.
REQ-035 Shadow loaded (pending=1), rst_n low one cycle -> all outputs 0x00, pending 0, next grant to A.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter_pkg: shared widths, register map and requester IDs for the write arbiter.
package reg_write_arbiter_pkg;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int NUM_REGS = 5;
    localparam int ADDR_OUT_7_0 = 0;
    localparam int ADDR_OUT_15_8 = 1;
    localparam int ADDR_PWM_7_0 = 2;
    localparam int ADDR_PWM_15_8 = 3;
    localparam int ADDR_PWM_DUTY = 4;
    typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;
endpackage

// File: rtl/reg_write_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter; the loser of a grant gets priority next.
module rr_arbiter2
    import reg_write_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    a_valid,
    input  logic    b_valid,
    output logic    a_grant,
    output logic    b_grant,
    output req_id_t last_grant
);
    localparam logic [0:0] PRIO_A = 1'b0;
    localparam logic [0:0] PRIO_B = 1'b1;
    logic [0:0] prio_q, prio_d;
    req_id_t last_q, last_d;
    always_comb begin
        a_grant = rst_n && a_valid && (!b_valid || prio_q == PRIO_A);
        b_grant = rst_n && b_valid && (!a_valid || prio_q == PRIO_B);
        prio_d = a_grant ? PRIO_B : b_grant ? PRIO_A : prio_q;
        last_d = a_grant ? REQ_A : b_grant ? REQ_B : last_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= PRIO_A;
            last_q <= REQ_A;
        end else begin
            prio_q <= prio_d;
            last_q <= last_d;
        end
    end
    assign last_grant = last_q;
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: arbitrates two register write ports into a five-register bank,
// optionally staging writes in a shadow copy that is published at PWM period end.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int MAX_ADDR = 4,
    parameter int SYNC_UPDATE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              period_end,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle,
    output logic              update_pending,
    output logic              addr_err,
    output logic              last_grant
);
    logic [DATA_W-1:0] shadow_q [NUM_REGS];
    logic [DATA_W-1:0] out_q [NUM_REGS];
    logic pending_q, pending_d, addr_err_q, addr_err_d;
    logic wr_en, wr_ok;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    req_id_t grant_id;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .a_grant   (a_ready),
        .b_grant   (b_ready),
        .last_grant(grant_id)
    );

    always_comb begin
        wr_en = a_ready || b_ready;
        wr_addr = a_ready ? a_addr : b_addr;
        wr_data = a_ready ? a_data : b_data;
        wr_ok = wr_en && (wr_addr <= ADDR_W'(MAX_ADDR));
        addr_err_d = wr_en && !wr_ok;
        // a write on the same edge as period_end keeps the flag set for the next period
        pending_d = (SYNC_UPDATE != 0) && (wr_ok || (pending_q && !period_end));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
                out_q[i] <= '0;
            end
            pending_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            addr_err_q <= addr_err_d;
            if (SYNC_UPDATE != 0) begin
                if (period_end && pending_q) out_q <= shadow_q;
                for (int i = 0; i < NUM_REGS; i++)
                    if (wr_ok && wr_addr == ADDR_W'(i)) shadow_q[i] <= wr_data;
            end else begin
                for (int i = 0; i < NUM_REGS; i++)
                    if (wr_ok && wr_addr == ADDR_W'(i)) out_q[i] <= wr_data;
            end
        end
    end

    assign en_reg_out_7_0 = out_q[ADDR_OUT_7_0];
    assign en_reg_out_15_8 = out_q[ADDR_OUT_15_8];
    assign en_reg_pwm_7_0 = out_q[ADDR_PWM_7_0];
    assign en_reg_pwm_15_8 = out_q[ADDR_PWM_15_8];
    assign pwm_duty_cycle = out_q[ADDR_PWM_DUTY];
    assign update_pending = pending_q;
    assign addr_err = addr_err_q;
    assign last_grant = (grant_id == REQ_B);
endmodule
